// File: rtl/m16_frame_loader.sv
// m16_frame_loader: write-side controller for the M16 ping-pong frame memory.
// Round-robin loads source words into the half the serializer is not reading.
module m16_frame_loader #(
    parameter int NREQ = 4,
    parameter int AW   = 8,
    parameter int DW   = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iSwitch,
    input  logic [NREQ-1:0]      iReq,
    input  logic [NREQ*DW-1:0]   iData,
    input  logic                 iClrFlags,
    output logic [NREQ-1:0]      oAck,
    output logic                 oWrEn,
    output logic [AW:0]          oWrAddr,
    output logic [DW-1:0]        oWrData,
    output logic [AW:0]          oFillCnt,
    output logic                 oFull,
    output logic                 oUnderrun,
    output logic                 oOverrun
);

    localparam int GW = $clog2(NREQ);
    localparam logic [AW:0] HALF_WORDS = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        S_INIT,
        S_FILL,
        S_FULL
    } state_t;

    state_t            state_q, state_d;
    logic              sw_prev_q;
    logic              half_q, half_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [NREQ-1:0]   ack_mask_q, ack_mask_d;

    logic [NREQ-1:0]   ack_d;
    logic              wr_en_d;
    logic [AW:0]       wr_addr_d;
    logic [DW-1:0]     wr_data_d;
    logic [AW:0]       fill_cnt_d;
    logic              full_d;
    logic              underrun_d;
    logic              overrun_d;

    logic [NREQ-1:0]   eligible;
    logic              found;
    logic [GW-1:0]     grant;
    logic [GW-1:0]     cand;
    int                idx;

    logic              toggle;
    logic              restart;
    logic              set_under;
    logic              set_over;

    // Round-robin search: first eligible source after the last grant.
    always_comb begin
        eligible = iReq & ~ack_mask_q;
        found    = 1'b0;
        grant    = last_grant_q;
        idx      = 0;
        cand     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx  = (int'(last_grant_q) + i) % NREQ;
            cand = GW'(idx);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // Next-state and registered-output logic for the fill controller.
    always_comb begin
        state_d      = state_q;
        half_d       = half_q;
        last_grant_d = last_grant_q;
        ack_mask_d   = '0;
        ack_d        = '0;
        wr_en_d      = 1'b0;
        wr_addr_d    = oWrAddr;
        wr_data_d    = oWrData;
        fill_cnt_d   = oFillCnt;
        full_d       = oFull;
        restart      = 1'b0;
        set_under    = 1'b0;
        set_over     = 1'b0;
        toggle       = (iSwitch != sw_prev_q);

        unique case (state_q)
            S_INIT: begin
                half_d     = ~iSwitch;
                fill_cnt_d = '0;
                state_d    = S_FILL;
            end
            S_FILL: begin
                if (toggle) begin
                    restart   = 1'b1;
                    set_under = 1'b1;
                end else if (found) begin
                    ack_d[grant] = 1'b1;
                    wr_en_d      = 1'b1;
                    wr_addr_d    = {half_q, oFillCnt[AW-1:0]};
                    wr_data_d    = iData[grant*DW +: DW];
                    last_grant_d = grant;
                    ack_mask_d   = ack_d;
                    fill_cnt_d   = oFillCnt + 1'b1;
                    if (fill_cnt_d == HALF_WORDS) begin
                        state_d = S_FULL;
                        full_d  = 1'b1;
                    end
                end
            end
            S_FULL: begin
                set_over = |iReq;
                restart  = toggle;
            end
            default: state_d = S_INIT;
        endcase

        if (restart) begin
            half_d     = ~iSwitch;
            fill_cnt_d = '0;
            full_d     = 1'b0;
            state_d    = S_FILL;
        end

        underrun_d = set_under ? 1'b1 : (iClrFlags ? 1'b0 : oUnderrun);
        overrun_d  = set_over  ? 1'b1 : (iClrFlags ? 1'b0 : oOverrun);
    end

    // State and output registers; reset clears every output at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_INIT;
            sw_prev_q    <= 1'b0;
            half_q       <= 1'b0;
            last_grant_q <= GW'(NREQ - 1);
            ack_mask_q   <= '0;
            oAck         <= '0;
            oWrEn        <= 1'b0;
            oWrAddr      <= '0;
            oWrData      <= '0;
            oFillCnt     <= '0;
            oFull        <= 1'b0;
            oUnderrun    <= 1'b0;
            oOverrun     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sw_prev_q    <= iSwitch;
            half_q       <= half_d;
            last_grant_q <= last_grant_d;
            ack_mask_q   <= ack_mask_d;
            oAck         <= ack_d;
            oWrEn        <= wr_en_d;
            oWrAddr      <= wr_addr_d;
            oWrData      <= wr_data_d;
            oFillCnt     <= fill_cnt_d;
            oFull        <= full_d;
            oUnderrun    <= underrun_d;
            oOverrun     <= overrun_d;
        end
    end

endmodule

// File: tb/tb_m16_frame_loader.sv
// tb_m16_frame_loader: randomized scoreboard bench for m16_frame_loader.
// A queue-based reference model predicts writes and status per clock edge.
module tb_m16_frame_loader;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 12;
    localparam int HW   = 1 << AW;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               iSwitch = 1'b0;
    logic [NREQ-1:0]    iReq = '0;
    logic [NREQ*DW-1:0] iData = '0;
    logic               iClrFlags = 1'b0;
    logic [NREQ-1:0]    oAck;
    logic               oWrEn;
    logic [AW:0]        oWrAddr;
    logic [DW-1:0]      oWrData;
    logic [AW:0]        oFillCnt;
    logic               oFull;
    logic               oUnderrun;
    logic               oOverrun;

    m16_frame_loader #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk),
        .reset(reset),
        .iSwitch(iSwitch),
        .iReq(iReq),
        .iData(iData),
        .iClrFlags(iClrFlags),
        .oAck(oAck),
        .oWrEn(oWrEn),
        .oWrAddr(oWrAddr),
        .oWrData(oWrData),
        .oFillCnt(oFillCnt),
        .oFull(oFull),
        .oUnderrun(oUnderrun),
        .oOverrun(oOverrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ack; int wren; int cnt; int full; int und; int ovr;
    } st_t;
    typedef struct {
        int ack; int addr; int data;
    } wr_t;

    st_t st_q[$];
    wr_t wr_q[$];
    st_t s;
    wr_t w;

    int  n_checks = 0;
    int  n_fail = 0;
    bit  mon_en = 0;

    typedef enum {M_INIT, M_FILL, M_FULL} mphase_t;
    mphase_t m_phase;
    int m_swp, m_half, m_cnt, m_full, m_und, m_ovr, m_blocked;
    int rr[$];

    int src_req[NREQ];
    int src_data[NREQ];
    int src_age[NREQ];
    int en_mask = 0;
    int p_req = 0;
    int sw_val = 0;
    int clr_val = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = M_INIT;
        m_swp = 0; m_half = 0; m_cnt = 0;
        m_full = 0; m_und = 0; m_ovr = 0;
        m_blocked = -1;
        rr.delete();
        for (int k = 0; k < NREQ; k++) rr.push_back(k);
    endtask

    // Search the service order (front = highest priority) for a requester.
    function automatic int pick();
        for (int j = 0; j < NREQ; j++) begin
            if (src_req[rr[j]] != 0 && rr[j] != m_blocked) return rr[j];
        end
        return -1;
    endfunction

    // Predict the DUT response to the inputs about to be sampled.
    task automatic model_step();
        int g;
        int any_req;
        int set_u;
        int set_o;
        int ack;
        int wren;
        g = -1; any_req = 0; set_u = 0; set_o = 0; ack = 0; wren = 0;
        for (int k = 0; k < NREQ; k++) if (src_req[k] != 0) any_req = 1;
        if (m_phase == M_INIT) begin
            m_half = (sw_val == 0) ? 1 : 0;
            m_cnt = 0;
            m_phase = M_FILL;
            m_blocked = -1;
        end else begin
            if (m_phase == M_FULL) set_o = any_req;
            if (sw_val != m_swp) begin
                set_u = (m_phase == M_FILL) ? 1 : 0;
                m_half = (sw_val == 0) ? 1 : 0;
                m_cnt = 0;
                m_full = 0;
                m_phase = M_FILL;
                m_blocked = -1;
            end else if (m_phase == M_FILL) begin
                g = pick();
                if (g >= 0) begin
                    ack = 1 << g;
                    wren = 1;
                    wr_q.push_back('{ack, m_half * HW + m_cnt, src_data[g]});
                    while (rr[NREQ-1] != g) rr.push_back(rr.pop_front());
                    m_blocked = g;
                    src_age[g] = 1;
                    m_cnt++;
                    if (m_cnt == HW) begin
                        m_full = 1;
                        m_phase = M_FULL;
                    end
                end else begin
                    m_blocked = -1;
                end
            end else begin
                m_blocked = -1;
            end
        end
        m_swp = sw_val;
        m_und = (set_u != 0) ? 1 : ((clr_val != 0) ? 0 : m_und);
        m_ovr = (set_o != 0) ? 1 : ((clr_val != 0) ? 0 : m_ovr);
        st_q.push_back('{ack, wren, m_cnt, m_full, m_und, m_ovr});
    endtask

    // Sources hold request/data until one cycle after their acknowledge.
    task automatic drive_cycle();
        for (int k = 0; k < NREQ; k++) begin
            if (src_age[k] == 1) begin
                src_age[k] = 2;
            end else begin
                if (src_age[k] == 2) begin
                    src_age[k] = 0;
                    src_req[k] = 0;
                end
                if (src_req[k] == 0 && en_mask[k] &&
                    $urandom_range(99) < p_req) begin
                    src_req[k] = 1;
                    src_data[k] = int'($urandom_range(4095));
                end
            end
        end
        iSwitch = sw_val[0];
        iClrFlags = clr_val[0];
        for (int k = 0; k < NREQ; k++) begin
            iReq[k] = src_req[k][0];
            iData[k*DW +: DW] = src_data[k][DW-1:0];
        end
        model_step();
    endtask

    task automatic step();
        @(negedge clk);
        drive_cycle();
    endtask

    task automatic fill_until(input int target, input int budget);
        int n;
        n = 0;
        while (m_cnt != target && n < budget) begin
            step();
            n++;
        end
        if (m_cnt != target) begin
            n_checks++;
            n_fail++;
            $display("FAIL fill_budget: got count %0d, required %0d",
                     m_cnt, target);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, oAck, 0);
        check({tag, "_wren"}, oWrEn, 0);
        check({tag, "_addr"}, oWrAddr, 0);
        check({tag, "_data"}, oWrData, 0);
        check({tag, "_cnt"}, oFillCnt, 0);
        check({tag, "_full"}, oFull, 0);
        check({tag, "_under"}, oUnderrun, 0);
        check({tag, "_over"}, oOverrun, 0);
    endtask

    task automatic clear_sources();
        for (int k = 0; k < NREQ; k++) begin
            src_req[k] = 0;
            src_data[k] = 0;
            src_age[k] = 0;
        end
    endtask

    // Monitor: pop expectations after every active edge and compare.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (st_q.size() == 0) begin
                check("status_queue_empty", 1, 0);
            end else begin
                s = st_q.pop_front();
                check("ack", oAck, s.ack);
                check("wren", oWrEn, s.wren);
                check("fill_cnt", oFillCnt, s.cnt);
                check("full", oFull, s.full);
                check("underrun", oUnderrun, s.und);
                check("overrun", oOverrun, s.ovr);
            end
            if (oWrEn) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", oWrAddr, 'hFFFF);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_ack", oAck, w.ack);
                    check("wr_addr", oWrAddr, w.addr);
                    check("wr_data", oWrData, w.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        clear_sources();
        repeat (2) @(negedge clk);
        check_all_zero("reset");

        // Single source into half 1 at one word per two cycles.
        en_mask = 1; p_req = 100;
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1;
        drive_cycle();
        fill_until(HW, 700);
        @(negedge clk);
        check("half1_full", oFull, 1);
        check("half1_cnt", oFillCnt, HW);
        check("half1_last_addr", oWrAddr, 'h1FF);

        // All sources request while FULL: overrun, no writes.
        en_mask = 'hF;
        drive_cycle();
        repeat (4) step();
        @(negedge clk);
        check("overrun_set", oOverrun, 1);
        check("full_no_wren", oWrEn, 0);
        sw_val = 1;
        drive_cycle();
        step();
        @(negedge clk);
        check("after_toggle_addr", oWrAddr, 'h000);
        check("after_toggle_ack", oAck, 2);
        check("after_toggle_full", oFull, 0);
        check("after_toggle_under", oUnderrun, 0);
        clr_val = 1;
        drive_cycle();
        clr_val = 0;

        // Four sources fill half 0; toggle in the first FULL cycle.
        fill_until(HW, 400);
        @(negedge clk);
        check("half0_last_addr", oWrAddr, 'h0FF);
        check("half0_full", oFull, 1);
        sw_val = 0;
        drive_cycle();
        @(negedge clk);
        check("boundary_no_underrun", oUnderrun, 0);
        drive_cycle();

        // Early toggle after 100 words sets underrun; clear it.
        fill_until(100, 300);
        @(negedge clk);
        sw_val = 1;
        drive_cycle();
        @(negedge clk);
        check("underrun_set", oUnderrun, 1);
        check("underrun_cnt_reset", oFillCnt, 0);
        clr_val = 1;
        drive_cycle();
        @(negedge clk);
        check("underrun_cleared", oUnderrun, 0);
        clr_val = 0;
        drive_cycle();

        // Random traffic, toggles and flag clears.
        p_req = 60;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(299) == 0) sw_val = 1 - sw_val;
            clr_val = ($urandom_range(79) == 0) ? 1 : 0;
            drive_cycle();
        end
        clr_val = 0;

        // Reset in the middle of a fill.
        repeat (37) step();
        @(negedge clk);
        mon_en = 0;
        #2 reset = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        st_q.delete();
        wr_q.delete();
        model_reset();
        clear_sources();
        sw_val = int'($urandom_range(1));
        reset = 1'b1;
        mon_en = 1;
        drive_cycle();
        repeat (60) step();

        @(negedge clk);
        mon_en = 0;
        check("wr_queue_drained", wr_q.size(), 0);
        check("st_queue_drained", st_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
